chord_mixer: RTL and testbench

Downstream of the three note players driven by `song_reader`. Per output sample it requests one sample from each active voice via `generate_next_sample`, collects the returned samples (each with its own ready strobe), sums them, scales and saturates the result, and presents one mixed 16-bit sample with a single-cycle ready pulse to the codec/output stage. A timeout keeps a stalled player from blocking the output stream.

---
 rtl/synth_pkg.sv | 14 +
 rtl/sat_shift.sv | 27 ++
 rtl/chord_mixer.sv | 149 ++++++++++++++
 tb/tb_chord_mixer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the synth datapath: sample width, voice count and mixer FSM states.
// Used by song_reader, the note players and the chord mixer.
package synth_pkg;

    localparam int SAMPLE_WIDTH = 16;
    localparam int NUM_VOICES   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SUM     = 2'd2
    } mixer_state_t;

endpackage

// File: rtl/sat_shift.sv
// Combinational arithmetic right shift of a WIDTH+2 bit signed sum followed by a clamp
// to the signed WIDTH-bit range.
module sat_shift #(
    parameter int WIDTH = 16,
    parameter int SHIFT = 1
) (
    input  logic signed [WIDTH+1:0] sum_i,
    output logic signed [WIDTH-1:0] sat_o
);

    localparam logic signed [WIDTH+1:0] MAX_V = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0] MIN_V = {3'b111, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH+1:0] shifted;

    always_comb begin
        shifted = sum_i >>> SHIFT;
        if (shifted > MAX_V) begin
            sat_o = MAX_V[WIDTH-1:0];
        end else if (shifted < MIN_V) begin
            sat_o = MIN_V[WIDTH-1:0];
        end else begin
            sat_o = shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/chord_mixer.sv
// Collects one sample from each active voice per request, sums, scales and saturates them,
// and emits one mixed sample with a single-cycle ready pulse; a timeout bounds stalled voices.
module chord_mixer
    import synth_pkg::*;
#(
    parameter int WIDTH   = SAMPLE_WIDTH,
    parameter int SHIFT   = 1,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    generate_next_sample,
    input  logic [NUM_VOICES-1:0]   voice_active,
    input  logic signed [WIDTH-1:0] sample_in1,
    input  logic signed [WIDTH-1:0] sample_in2,
    input  logic signed [WIDTH-1:0] sample_in3,
    input  logic                    sample_ready1,
    input  logic                    sample_ready2,
    input  logic                    sample_ready3,
    output logic signed [WIDTH-1:0] sample_out,
    output logic                    new_sample_ready,
    output logic [NUM_VOICES-1:0]   dropped,
    output logic                    busy
);

    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    mixer_state_t            state_q, state_d;
    logic [NUM_VOICES-1:0]   mask_q, mask_d;
    logic [NUM_VOICES-1:0]   valid_q, valid_d;
    logic [NUM_VOICES-1:0]   dropped_q, dropped_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [WIDTH-1:0] samp_q [NUM_VOICES];
    logic signed [WIDTH-1:0] samp_d [NUM_VOICES];
    logic signed [WIDTH-1:0] out_q, out_d;
    logic                    nsr_q, nsr_d;

    logic [NUM_VOICES-1:0]   incoming;
    logic signed [WIDTH-1:0] sin [NUM_VOICES];
    logic signed [WIDTH+1:0] sum;
    logic signed [WIDTH-1:0] mixed;

    assign incoming = {sample_ready3, sample_ready2, sample_ready1};
    assign sin[0]   = sample_in1;
    assign sin[1]   = sample_in2;
    assign sin[2]   = sample_in3;

    always_comb begin
        sum = '0;
        for (int n = 0; n < NUM_VOICES; n++) begin
            if (mask_q[n] && valid_q[n]) begin
                sum = sum + {{2{samp_q[n][WIDTH-1]}}, samp_q[n]};
            end
        end
    end

    sat_shift #(
        .WIDTH (WIDTH),
        .SHIFT (SHIFT)
    ) u_sat_shift (
        .sum_i (sum),
        .sat_o (mixed)
    );

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        samp_d    = samp_q;
        out_d     = out_q;
        dropped_d = dropped_q;
        nsr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (generate_next_sample) begin
                    // The accept cycle already captures strobes, so it counts as the
                    // first collection cycle of the timeout window.
                    mask_d  = voice_active;
                    valid_d = voice_active & incoming;
                    cnt_d   = CW'(1);
                    for (int n = 0; n < NUM_VOICES; n++) begin
                        if (voice_active[n] && incoming[n]) begin
                            samp_d[n] = sin[n];
                        end
                    end
                    state_d = ((voice_active & incoming) == voice_active) ? SUM : COLLECT;
                end
            end

            COLLECT: begin
                for (int n = 0; n < NUM_VOICES; n++) begin
                    if (mask_q[n] && incoming[n] && !valid_q[n]) begin
                        samp_d[n]  = sin[n];
                        valid_d[n] = 1'b1;
                    end
                end
                if ((((valid_q | incoming) & mask_q) == mask_q) || (cnt_q == CNT_LAST)) begin
                    state_d = SUM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            SUM: begin
                out_d     = mixed;
                dropped_d = mask_q & ~valid_q;
                nsr_d     = 1'b1;
                state_d   = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            valid_q   <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            dropped_q <= '0;
            nsr_q     <= 1'b0;
            for (int n = 0; n < NUM_VOICES; n++) begin
                samp_q[n] <= '0;
            end
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            dropped_q <= dropped_d;
            nsr_q     <= nsr_d;
            for (int n = 0; n < NUM_VOICES; n++) begin
                samp_q[n] <= samp_d[n];
            end
        end
    end

    assign sample_out       = out_q;
    assign new_sample_ready = nsr_q;
    assign dropped          = dropped_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_chord_mixer.sv
// Scoreboard bench for chord_mixer: each request pushes its expected mix, drop mask and
// output cycle; a negedge monitor pops and compares on every new_sample_ready pulse.
module tb_chord_mixer;
    import synth_pkg::*;

    localparam int W  = 16;
    localparam int TO = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic                generate_next_sample;
    logic [2:0]          voice_active;
    logic signed [W-1:0] sample_in1, sample_in2, sample_in3;
    logic                sample_ready1, sample_ready2, sample_ready3;
    logic signed [W-1:0] sample_out;
    logic                new_sample_ready;
    logic [2:0]          dropped;
    logic                busy;

    typedef struct {
        logic signed [W-1:0] s;
        logic [2:0]          d;
        int                  at;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    chord_mixer #(.WIDTH(W), .SHIFT(1), .TIMEOUT(TO)) dut (
        .clk                  (clk),
        .reset                (reset),
        .generate_next_sample (generate_next_sample),
        .voice_active         (voice_active),
        .sample_in1           (sample_in1),
        .sample_in2           (sample_in2),
        .sample_in3           (sample_in3),
        .sample_ready1        (sample_ready1),
        .sample_ready2        (sample_ready2),
        .sample_ready3        (sample_ready3),
        .sample_out           (sample_out),
        .new_sample_ready     (new_sample_ready),
        .dropped              (dropped),
        .busy                 (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (new_sample_ready) begin
            check_eq("pulse_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("sample_out", sample_out, e.s);
                check_eq("dropped", {29'd0, dropped}, {29'd0, e.d});
                check_eq("pulse_cycle", cyc, e.at);
            end
        end
    end

    task automatic drive_idle(input int n);
        for (int r = 0; r < n; r++) begin
            @(negedge clk);
            generate_next_sample = 1'b0;
            voice_active         = 3'b000;
            sample_ready1        = 1'b0;
            sample_ready2        = 1'b0;
            sample_ready3        = 1'b0;
        end
    endtask

    // k = strobe cycle relative to accept (-1: never); voice 1 may strobe again at dupk.
    task automatic run_txn(input logic [2:0] mask,
                           input int k1, input int k2, input int k3,
                           input logic signed [W-1:0] v1, input logic signed [W-1:0] v2,
                           input logic signed [W-1:0] v3,
                           input bit regen, input int dupk, input logic signed [W-1:0] dupv);
        int                  ka[3];
        logic signed [W-1:0] vv[3];
        logic signed [W-1:0] din[3];
        logic [2:0]          rdy;
        logic [2:0]          dr;
        int                  kd, lat, acc;
        bit                  full;
        exp_t                e;
        ka[0] = k1; ka[1] = k2; ka[2] = k3;
        vv[0] = v1; vv[1] = v2; vv[2] = v3;
        full = 1'b1;
        kd   = 0;
        for (int n = 0; n < 3; n++) begin
            if (mask[n]) begin
                if (ka[n] < 0 || ka[n] > TO - 1) full = 1'b0;
                else if (ka[n] > kd) kd = ka[n];
            end
        end
        if (!full) kd = TO - 1;
        acc = 0;
        dr  = 3'b000;
        for (int n = 0; n < 3; n++) begin
            if (mask[n]) begin
                if (ka[n] >= 0 && ka[n] <= kd) acc += int'(vv[n]);
                else dr[n] = 1'b1;
            end
        end
        acc = acc >>> 1;
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        lat = kd + 2;
        for (int r = 0; r < lat; r++) begin
            @(negedge clk);
            if (r == 0) begin
                e.s = 16'(acc);
                e.d = dr;
                e.at = cyc + lat;
                sb.push_back(e);
                check_eq("busy_at_accept", {31'd0, busy}, 32'd0);
            end
            if (r == 1) check_eq("busy_after_accept", {31'd0, busy}, 32'd1);
            generate_next_sample = (r == 0) || (regen && r == 1);
            voice_active         = (r == 0) ? mask : ~mask;
            for (int n = 0; n < 3; n++) begin
                rdy[n] = (ka[n] == r) || (n == 0 && dupk == r);
                if (ka[n] == r) din[n] = vv[n];
                else if (n == 0 && dupk == r) din[n] = dupv;
                else din[n] = 16'($urandom);
            end
            sample_ready1 = rdy[0];
            sample_ready2 = rdy[1];
            sample_ready3 = rdy[2];
            sample_in1    = din[0];
            sample_in2    = din[1];
            sample_in3    = din[2];
        end
    endtask

    initial begin
        reset                = 1'b1;
        generate_next_sample = 1'b0;
        voice_active         = 3'b000;
        sample_in1           = '0;
        sample_in2           = '0;
        sample_in3           = '0;
        sample_ready1        = 1'b0;
        sample_ready2        = 1'b0;
        sample_ready3        = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_sample_out", sample_out, 32'd0);
        check_eq("rst_nsr", {31'd0, new_sample_ready}, 32'd0);
        check_eq("rst_dropped", {29'd0, dropped}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        drive_idle(2);

        // Staggered returns, then back-to-back requests.
        run_txn(3'b111, 3, 5, 4, 16'sd1000, 16'sd2000, 16'sd3000, 1'b0, -1, 16'sd0);
        run_txn(3'b111, 2, 2, 2, 16'sd32767, 16'sd32767, 16'sd32767, 1'b0, -1, 16'sd0);
        run_txn(3'b111, 1, 1, 1, -16'sd32768, -16'sd32768, -16'sd32768, 1'b0, -1, 16'sd0);
        run_txn(3'b101, 1, 1, 2, 16'sd100, 16'sd5000, 16'sd100, 1'b0, -1, 16'sd0);
        run_txn(3'b111, 0, 0, 0, -16'sd100, 16'sd50, 16'sd7, 1'b0, -1, 16'sd0);
        run_txn(3'b111, 1, 1, -1, 16'sd200, 16'sd200, 16'sd0, 1'b0, -1, 16'sd0);
        run_txn(3'b100, -1, -1, TO - 1, 16'sd0, 16'sd0, 16'sd1000, 1'b0, -1, 16'sd0);
        run_txn(3'b000, 0, 1, -1, 16'sd300, 16'sd300, 16'sd0, 1'b1, -1, 16'sd0);
        drive_idle(3);

        // Reset mid-collection with voice 1 already captured.
        @(negedge clk);
        generate_next_sample = 1'b1;
        voice_active         = 3'b111;
        @(negedge clk);
        generate_next_sample = 1'b0;
        sample_ready1        = 1'b1;
        sample_in1           = 16'sd7;
        @(negedge clk);
        sample_ready1        = 1'b0;
        reset                = 1'b1;
        @(negedge clk);
        reset                = 1'b0;
        check_eq("abort_sample_out", sample_out, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        drive_idle(4);

        run_txn(3'b011, 1, 4, -1, 16'sd10, 16'sd20, 16'sd0, 1'b0, 2, 16'sd90);
        drive_idle(4);

        check_eq("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
